conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Frame-level sequencer for the 3x3 `convolution` edge core. It accepts a raster-order 8-bit pixel stream and builds each 3x3 neighbourhood using two line buffers and a window register. It drives the core's nine pixel inputs and threshold, then returns the core's edge bit through a registered valid/ready output stage. One instance sits between the pixel source and the edge-map sink. The core is instantiated beside it, not inside it.

## Interface
- IMG_W, 64: pixels per line (≥3)
- IMG_H, 64: lines per frame (≥3)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle frame start; ignored unless IDLE
- t_in  in  8  threshold, latched on accepted start
- pix_in  in  8  input pixel, raster order
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  controller accepts pix_in this cycle
- p0..p8  out  8 each  window to core (p0 top-left … p2 top-right, p3..p5 middle, p6..p8 bottom; p8 = newest pixel)
- t  out  8  latched threshold to core
- core_d  in  1  core edge result (bit 0 of core d)
- out_d  out  1  registered edge bit
- out_valid  out  1  out_d valid
- out_ready  in  1  sink accepts out_d
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE→STREAM on start: clear row/col counters; latch t_in into t.
  - STREAM→DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
  - DRAIN→DONE when win_valid=0 and out_valid=0.
  - DONE→IDLE unconditionally; done=1 only in DONE.
- advance = !out_valid || out_ready.
- pix_ready = (state==STREAM) && advance.
- Accept = pix_valid && pix_ready. On accept at (row, col):
  - Window shifts left one column. New right column is {lb1[col], lb0[col], pix_in} for top, middle, bottom.
  - lb1[col] ← lb0[col]; lb0[col] ← pix_in.
  - col increments; it wraps to 0 at IMG_W-1 and row increments.
- win_valid ← accept && row≥2 && col≥2. It is cleared on any advance cycle without an accept.
- On advance: out_valid ← win_valid; out_d ← core_d. The core is purely combinational on p0..p8 and t.
- Frame produces exactly (IMG_W-2)·(IMG_H-2) outputs in raster order. Border pixels produce no output.
- Line buffers are IMG_W×8 each and need no reset. Stale contents never reach a valid window because rows 0–1 are rewritten first.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H).

## Timing
- Reset values: pix_ready=0, out_valid=0, out_d=0, busy=0, done=0, t=0, p0..p8=0, win_valid=0, state=IDLE, counters=0.
- Latency: pixel accepted at edge E. Its window is valid after E. Its out_d/out_valid appear after edge E+1, provided advance holds.
- out_valid && !out_ready: out_d, out_valid, window and win_valid hold, and pix_ready=0. No pixel is accepted and no output is lost or duplicated.
- Output transfer and pixel accept can occur in the same cycle. Sustained throughput is 1 pixel/cycle with out_ready=1.
- pix_valid low mid-line: counters and window hold; pending output still drains.
- start during STREAM/DRAIN/DONE: ignored, and t is unchanged.
- Minimum frame time with no stalls is IMG_W·IMG_H+3 cycles from start to done.
- rst_n low mid-frame clears all state asynchronously. The next frame needs a new start. A partially sent frame is not resumed.

## Test plan
- Flat frame: IMG_W=IMG_H=4, all pixels 100, t_in=1, real core, out_ready=1 → exactly 4 outputs, all out_d=0, done pulses once, busy falls with done.
- Same frame with t_in=0 → 4 outputs, all out_d=1.
- Vertical step: 4×4 frame, columns 0,0,200,200 on every row, t_in=10 → 4 outputs, all out_d=1.
- Backpressure: 8×8 random frame, out_ready toggled randomly ~50% → 36 outputs, identical sequence to the out_ready=1 run, pix_ready=0 whenever out_valid && !out_ready.
- Source gaps plus start abuse: pix_valid random, start pulsed mid-frame with t_in=255 → output count unchanged, t keeps its original value.
- Reset mid-frame: rst_n low after 20 pixels of a 8×8 frame → all outputs zero immediately; a following full frame yields 36 correct outputs.

Source files
------------

// File: rtl/conv_window_ctrl_if.sv
// Pixel-in and edge-bit-out valid/ready streams of the 3x3 window sequencer.
// The slave side is the controller; the master side is the source/sink environment.
interface conv_window_ctrl_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic       out_d;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output pix_in, pix_valid, out_ready,
    input  pix_ready, out_d, out_valid
  );

  modport slave (
    input  pix_in, pix_valid, out_ready,
    output pix_ready, out_d, out_valid
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the 3x3 edge core: line buffers plus window register feed
// p0..p8, and the core's combinational result is returned through a registered stage.
module conv_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           t_in,
  conv_window_ctrl_if.slave    bus,
  output logic [7:0]           p0,
  output logic [7:0]           p1,
  output logic [7:0]           p2,
  output logic [7:0]           p3,
  output logic [7:0]           p4,
  output logic [7:0]           p5,
  output logic [7:0]           p6,
  output logic [7:0]           p7,
  output logic [7:0]           p8,
  output logic [7:0]           t,
  input  logic                 core_d,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          win_valid;
  logic          advance;
  logic          accept;
  logic          col_last;
  logic          last_pix;
  logic          out_valid_q;
  logic          out_d_q;

  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];

  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.pix_ready = (state == STREAM) && advance;
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign col_last      = (col == COL_LAST);
  assign last_pix      = col_last && (row == ROW_LAST);
  assign bus.out_valid = out_valid_q;
  assign bus.out_d     = out_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    unique case (state)
      IDLE:   if (start) state_nxt = STREAM;
      STREAM: if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:  if (!win_valid && !out_valid_q) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line buffers carry no reset: rows 0-1 of every frame overwrite them before
  // any window that reads them can be flagged valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t   <= '0;
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      t   <= t_in;
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= '0; p1 <= '0; p2 <= '0;
      p3 <= '0; p4 <= '0; p5 <= '0;
      p6 <= '0; p7 <= '0; p8 <= '0;
    end else if (accept) begin
      p0 <= p1; p1 <= p2; p2 <= lb1[col];
      p3 <= p4; p4 <= p5; p5 <= lb0[col];
      p6 <= p7; p7 <= p8; p8 <= bus.pix_in;
    end
  end

  // The window and its valid flag only move on advance, so a stalled output
  // keeps the core result it was computed from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid   <= 1'b0;
      out_valid_q <= 1'b0;
      out_d_q     <= 1'b0;
    end else begin
      if (accept) begin
        win_valid <= (row >= RW'(2)) && (col >= CW'(2));
      end else if (advance) begin
        win_valid <= 1'b0;
      end
      if (advance) begin
        out_valid_q <= win_valid;
        out_d_q     <= core_d;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: a Sobel-style edge core beside the DUT, and an
// image-array model that predicts every window and edge bit in raster order.
`timescale 1ns/1ps
module tb_conv_window_ctrl;
  localparam int W    = 7;
  localparam int H    = 5;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic [7:0] t_in  = '0;
  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8, t;
  logic       core_d, busy, done;

  conv_window_ctrl_if bus();

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .t_in(t_in), .bus(bus),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .t(t), .core_d(core_d), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Edge core: |gx|+|gy| of the Sobel kernels compared against the threshold.
  function automatic logic edge_fn(input logic [71:0] w, input logic [7:0] th);
    int v[9];
    int gx, gy;
    for (int i = 0; i < 9; i++) v[i] = int'(w[8*i +: 8]);
    gx = (v[2] + 2*v[5] + v[8]) - (v[0] + 2*v[3] + v[6]);
    gy = (v[6] + 2*v[7] + v[8]) - (v[0] + 2*v[1] + v[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy) >= int'(th);
  endfunction

  assign core_d = edge_fn({p8, p7, p6, p5, p4, p3, p2, p1, p0}, t);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  int         img [H][W];
  int         mr, mc;
  logic [7:0] mt;
  bit         exp_q [$];
  bit         got_q [$];
  bit         ref_q [$];
  int         n_out, n_ones, n_done;
  bit         pend, done_prev;
  logic [71:0] pend_win;
  int         cyc = 0;
  int         cyc_start, cyc_done;
  int         src [H*W];

  function automatic logic [71:0] window(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[8*(dr*3 + dc) +: 8] = 8'(img[r - 2 + dr][c - 2 + dc]);
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      mr = 0; mc = 0; pend = 0; done_prev = 0;
      exp_q.delete();
    end else begin
      if (pend) begin
        chkw("window", {p8, p7, p6, p5, p4, p3, p2, p1, p0}, pend_win);
        pend = 0;
      end
      if (bus.out_valid && !bus.out_ready)
        chk("stall_pix_ready", int'(bus.pix_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", exp_q.size(), 1);
        else chk("out_d", int'(bus.out_d), int'(exp_q.pop_front()));
        got_q.push_back(bus.out_d);
        n_out++;
        n_ones += int'(bus.out_d);
      end
      if (busy) chk("t_latched", int'(t), int'(mt));
      if (done_prev) chk("idle_after_done", int'({busy, done}), 0);
      done_prev = done;
      if (done) begin
        n_done++;
        cyc_done = cyc;
      end
      if (start && !busy) begin
        mt = t_in; mr = 0; mc = 0;
        exp_q.delete(); got_q.delete();
        n_out = 0; n_ones = 0; n_done = 0;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        img[mr][mc] = int'(bus.pix_in);
        if (mr >= 2 && mc >= 2) begin
          pend_win = window(mr, mc);
          pend = 1;
          exp_q.push_back(edge_fn(pend_win, mt));
        end
        if (mc == W - 1) begin
          mc = 0;
          mr++;
        end else begin
          mc++;
        end
      end
    end
  end

  // pat: 0 random, 1 flat 100, 2 vertical step, 3 reuse previous image.
  task automatic run_frame(input int pat, input logic [7:0] th, input int vpct,
                           input int rpct, input bit abuse, input int rst_at);
    int idx, guard;
    bit acc;
    for (int i = 0; i < H*W; i++) begin
      if (pat == 0) src[i] = $urandom_range(255);
      else if (pat == 1) src[i] = 100;
      else if (pat == 2) src[i] = ((i % W) < 3) ? 0 : 200;
    end
    @(posedge clk); #1;
    start = 1'b1;
    t_in  = th;
    @(posedge clk); #1;
    cyc_start = cyc;
    start = 1'b0;
    t_in  = 8'($urandom_range(255));
    idx = 0;
    guard = 0;
    while (idx < W*H && guard < 5000) begin
      bus.pix_valid = ($urandom_range(99) < vpct);
      bus.pix_in    = 8'(src[idx]);
      bus.out_ready = ($urandom_range(99) < rpct);
      if (abuse && guard == 2*W) begin
        start = 1'b1;
        t_in  = 8'd255;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      acc = bus.pix_valid && bus.pix_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
      if (rst_at > 0 && idx == rst_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        bus.pix_valid = 1'b0;
        #1;
        chk("reset_ctrl", int'({bus.pix_ready, bus.out_valid, bus.out_d, busy, done, t}), 0);
        chkw("reset_window", {p8, p7, p6, p5, p4, p3, p2, p1, p0}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
    if (guard >= 5000) chk("pixel_timeout", idx, W*H);
    bus.pix_valid = 1'b0;
    guard = 0;
    while (n_done == 0 && guard < 500) begin
      bus.out_ready = ($urandom_range(99) < rpct);
      @(posedge clk); #1;
      guard++;
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", n_done, 1);
    chk("out_count", n_out, NOUT);
    chk("exp_left", exp_q.size(), 0);
    if (vpct == 100 && rpct == 100) chk("frame_cycles", cyc_done - cyc_start, W*H + 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] th;
    rst_n = 1'b0;
    bus.pix_in = '0;
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", int'({bus.pix_ready, bus.out_valid, bus.out_d, busy, done, t}), 0);
    chkw("rst_window", {p8, p7, p6, p5, p4, p3, p2, p1, p0}, '0);
    rst_n = 1'b1;

    run_frame(1, 8'd1, 100, 100, 0, 0);
    chk("flat_t1_ones", n_ones, 0);
    run_frame(1, 8'd0, 100, 100, 0, 0);
    chk("flat_t0_ones", n_ones, NOUT);
    run_frame(2, 8'd10, 100, 100, 0, 0);
    chk("step_ones", n_ones, 6);

    th = 8'($urandom_range(40, 400 > 255 ? 255 : 200));
    run_frame(0, th, 100, 100, 0, 0);
    ref_q = got_q;
    run_frame(3, th, 100, 50, 0, 0);
    chk("bp_seq_len", got_q.size(), ref_q.size());
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      chk("bp_seq", int'(got_q[i]), int'(ref_q[i]));

    th = 8'($urandom_range(255));
    run_frame(0, th, 60, 70, 1, 0);
    chk("abuse_t", int'(t), int'(th));

    run_frame(0, 8'($urandom_range(255)), 100, 100, 0, 20);
    chk("post_reset_idle", int'(busy), 0);
    run_frame(0, 8'($urandom_range(255)), 100, 100, 0, 0);

    for (int k = 0; k < 4; k++)
      run_frame(0, 8'($urandom_range(255)), $urandom_range(30, 100), $urandom_range(30, 100), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
